// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants for the fetch unit and the control unit:
// instruction field positions and opcode encodings.
package fetch_unit_pkg;

  // Instruction field positions (16-bit instruction word)
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int SRC_HI = 7;
  localparam int SRC_LO = 4;
  localparam int REP_HI = 3;
  localparam int REP_LO = 0;

  localparam int REP_W = REP_HI - REP_LO + 1;
  localparam int OPC_W = OPC_HI - OPC_LO + 1;

  // Halt opcode; the only encoding the fetch unit itself decodes
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/fetch_unit_rep_counter.sv
// Saturating repeat counter for multi-word operations. Counts up to
// the instruction's rep field and holds there; rep_stop flags the end.
module rep_counter
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rep_reset,
  input  logic             rep_enable,
  input  logic [REP_W-1:0] limit,
  output logic [REP_W-1:0] cnt,
  output logic             rep_stop
);

  logic [REP_W-1:0] cnt_reg;
  logic [REP_W-1:0] cnt_next;

  // Next count: clear beats advance; advance only while below the limit,
  // so the counter never wraps and a stale count above the limit holds.
  always_comb begin
    cnt_next = cnt_reg;
    if (rep_reset) begin
      cnt_next = '0;
    end else if (rep_enable && (cnt_reg < limit)) begin
      cnt_next = cnt_reg + REP_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt      = cnt_reg;
  assign rep_stop = (cnt_reg == limit);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, instruction register, and
// the repeat counter that walks operand addresses for multi-word ops.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_reset,
  input  logic            pc_enable,
  input  logic            pc_load,
  input  logic            ir_enable,
  input  logic            rep_reset,
  input  logic            rep_enable,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  output logic [3:0]      opcode_new,
  output logic [3:0]      opcode_old,
  output logic            rep_stop,
  output logic [AW-1:0]   dst_addr,
  output logic [AW-1:0]   src_addr,
  output logic [DW-1:0]   imm,
  output logic [3:0]      rep_idx,
  output logic            halted
);

  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  pc_next;
  logic [IW-1:0]    ir_reg;
  logic [IW-1:0]    ir_next;
  logic [REP_W-1:0] rep_cnt;

  // PC next value: clear > branch load from the current IR > increment > hold
  always_comb begin
    pc_next = pc_reg;
    if (pc_reset) begin
      pc_next = '0;
    end else if (pc_load) begin
      pc_next = ir_reg[PC_W-1:0];
    end else if (pc_enable) begin
      pc_next = pc_reg + PC_W'(1);
    end
  end

  // IR captures the word currently addressed (old PC), independent of PC ops
  always_comb begin
    ir_next = ir_reg;
    if (ir_enable) begin
      ir_next = imem_data;
    end
  end

  // PC and IR registers; reset overrides every control input
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= '0;
      ir_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      ir_reg <= ir_next;
    end
  end

  rep_counter u_rep_counter (
    .clk        (clk),
    .reset      (reset),
    .rep_reset  (rep_reset),
    .rep_enable (rep_enable),
    .limit      (ir_reg[REP_HI:REP_LO]),
    .cnt        (rep_cnt),
    .rep_stop   (rep_stop)
  );

  assign imem_addr  = pc_reg;
  assign opcode_new = imem_data[OPC_HI:OPC_LO];
  assign opcode_old = ir_reg[OPC_HI:OPC_LO];
  assign rep_idx    = rep_cnt;
  assign halted     = (ir_reg[OPC_HI:OPC_LO] == OP_HLT);

  // Per-word operand addresses wrap modulo 2^AW
  assign dst_addr = AW'(ir_reg[DST_HI:DST_LO]) + AW'(rep_cnt);
  assign src_addr = AW'(ir_reg[SRC_HI:SRC_LO]) + AW'(rep_cnt);
  assign imm      = DW'(ir_reg[SRC_HI:SRC_LO]);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each stimulus step pushes the expected
// output snapshot; a negedge monitor pops and compares against the DUT.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_reset;
  logic        pc_enable;
  logic        pc_load;
  logic        ir_enable;
  logic        rep_reset;
  logic        rep_enable;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  opcode_new;
  logic [3:0]  opcode_old;
  logic        rep_stop;
  logic [3:0]  dst_addr;
  logic [3:0]  src_addr;
  logic [7:0]  imm;
  logic [3:0]  rep_idx;
  logic        halted;

  fetch_unit #(.PC_W(8), .IW(16), .AW(4), .DW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_reset   (pc_reset),
    .pc_enable  (pc_enable),
    .pc_load    (pc_load),
    .ir_enable  (ir_enable),
    .rep_reset  (rep_reset),
    .rep_enable (rep_enable),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .opcode_new (opcode_new),
    .opcode_old (opcode_old),
    .rep_stop   (rep_stop),
    .dst_addr   (dst_addr),
    .src_addr   (src_addr),
    .imm        (imm),
    .rep_idx    (rep_idx),
    .halted     (halted)
  );

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [3:0] opn;
    logic [3:0] opo;
    logic       stop;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] imm;
    logic [3:0] idx;
    logic       halt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (imem_addr !== mon_e.addr || opcode_new !== mon_e.opn ||
          opcode_old !== mon_e.opo || rep_stop !== mon_e.stop ||
          dst_addr !== mon_e.dst || src_addr !== mon_e.src ||
          imm !== mon_e.imm || rep_idx !== mon_e.idx || halted !== mon_e.halt) begin
        failures++;
        $display("FAIL %s: got addr=%h opn=%h opo=%h stop=%b dst=%h src=%h imm=%h idx=%h halt=%b; want addr=%h opn=%h opo=%h stop=%b dst=%h src=%h imm=%h idx=%h halt=%b",
                 mon_e.name, imem_addr, opcode_new, opcode_old, rep_stop, dst_addr,
                 src_addr, imm, rep_idx, halted, mon_e.addr, mon_e.opn, mon_e.opo,
                 mon_e.stop, mon_e.dst, mon_e.src, mon_e.imm, mon_e.idx, mon_e.halt);
      end else begin
        $display("check %s: addr=%h opo=%h idx=%h stop=%b dst=%h src=%h ok",
                 mon_e.name, imem_addr, opcode_old, rep_idx, rep_stop, dst_addr, src_addr);
      end
    end
  end

  // Drive one cycle's inputs after the falling edge, then step past the rising edge
  task automatic cyc(input logic rst, input logic pr, input logic pe, input logic pl,
                     input logic ie, input logic rr, input logic re, input logic [15:0] d);
    @(negedge clk);
    #1;
    reset = rst; pc_reset = pr; pc_enable = pe; pc_load = pl;
    ir_enable = ie; rep_reset = rr; rep_enable = re; imem_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] addr, input logic [3:0] opn,
                            input logic [3:0] opo, input logic stop, input logic [3:0] dst,
                            input logic [3:0] src, input logic [7:0] im, input logic [3:0] idx,
                            input logic halt);
    exp_t e;
    e.name = name; e.addr = addr; e.opn = opn; e.opo = opo; e.stop = stop;
    e.dst = dst; e.src = src; e.imm = im; e.idx = idx; e.halt = halt;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; pc_reset = 1'b0; pc_enable = 1'b0; pc_load = 1'b0;
    ir_enable = 1'b0; rep_reset = 1'b0; rep_enable = 1'b0; imem_data = 16'h6123;

    // 1. reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 16'h6123);
    expect_out("reset", 8'h00, 4'h6, 4'h0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0);

    // 2. PC increment and wrap
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 16'h6123);
      expect_out($sformatf("pc_inc%0d", i), 8'(i), 4'h6, 4'h0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h00FF);
    expect_out("ir_00ff", 8'h03, 4'h0, 4'h0, 0, 4'h0, 4'hF, 8'h0F, 4'h0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h00FF);
    expect_out("pc_load_ff", 8'hFF, 4'h0, 4'h0, 0, 4'h0, 4'hF, 8'h0F, 4'h0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 16'h00FF);
    expect_out("pc_wrap", 8'h00, 4'h0, 4'h0, 0, 4'h0, 4'hF, 8'h0F, 4'h0, 0);

    // 3. multi-word operation with rep field 3
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h6A53);
    expect_out("ir_6a53", 8'h00, 4'h6, 4'h6, 0, 4'hA, 4'h5, 8'h05, 4'h0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 16'h6A53);
      expect_out($sformatf("rep_step%0d", i), 8'h00, 4'h6, 4'h6, (i == 3),
                 4'(4'hA + i), 4'(4'h5 + i), 8'h05, 4'(i), 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h6A53);
    expect_out("rep_saturate", 8'h00, 4'h6, 4'h6, 1, 4'hD, 4'h8, 8'h05, 4'h3, 0);

    // 5a. rep_reset beats rep_enable
    cyc(0, 0, 0, 0, 0, 1, 0, 16'h6A53);
    expect_out("rep_clear", 8'h00, 4'h6, 4'h6, 0, 4'hA, 4'h5, 8'h05, 4'h0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h6A53);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h6A53);
    expect_out("rep_at2", 8'h00, 4'h6, 4'h6, 0, 4'hC, 4'h7, 8'h05, 4'h2, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 16'h6A53);
    expect_out("rep_reset_prio", 8'h00, 4'h6, 4'h6, 0, 4'hA, 4'h5, 8'h05, 4'h0, 0);

    // 4. load beats increment; IR takes the old-PC word
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h5042);
    expect_out("ir_5042", 8'h00, 4'h5, 4'h5, 0, 4'h0, 4'h4, 8'h04, 4'h0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0, 16'h7311);
    expect_out("load_beats_inc", 8'h42, 4'h7, 4'h7, 0, 4'h3, 4'h1, 8'h01, 4'h0, 0);

    // 5b. pc_reset beats pc_load
    cyc(0, 1, 0, 1, 0, 0, 0, 16'h7311);
    expect_out("pc_reset_prio", 8'h00, 4'h7, 4'h7, 0, 4'h3, 4'h1, 8'h01, 4'h0, 0);

    // 6. build pc=7, rep_idx=2 with rep field 3, then reset mid-operation
    cyc(0, 0, 1, 0, 1, 0, 0, 16'h2103);
    expect_out("ir_2103", 8'h01, 4'h2, 4'h2, 0, 4'h1, 4'h0, 8'h00, 4'h0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 16'h2103);
    cyc(0, 0, 1, 0, 0, 0, 1, 16'h2103);
    expect_out("mid_idx2", 8'h03, 4'h2, 4'h2, 0, 4'h3, 4'h2, 8'h00, 4'h2, 0);
    for (int i = 4; i <= 7; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 16'h2103);
      expect_out($sformatf("pc_to%0d", i), 8'(i), 4'h2, 4'h2, 0, 4'h3, 4'h2, 8'h00, 4'h2, 0);
    end
    cyc(1, 0, 1, 1, 1, 0, 1, 16'hF000);
    expect_out("reset_mid_op", 8'h00, 4'hF, 4'h0, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 16'hF000);
    expect_out("halt", 8'h00, 4'hF, 4'hF, 1, 4'h0, 4'h0, 8'h00, 4'h0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    expect_out("ir_hold", 8'h00, 4'h0, 4'hF, 1, 4'h0, 4'h0, 8'h00, 4'h0, 1);

    // Let the monitor drain, then confirm nothing was left unchecked
    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-side stage directly upstream of the control unit `cu`.
- Holds the program counter, drives the instruction-memory address and latches the executing instruction into the IR.
- Presents `opcode_new` (instruction at PC) and `opcode_old` (instruction in IR) to the control unit.
- Owns the multi-word repeat counter that produces `rep_stop` and the per-word operand addresses. It is controlled by the control unit's `pc_*`, `ir_enable` and `rep_*` outputs.

Parameters:
- PC_W, 8, program counter / instruction address width.
- IW, 16, instruction word width (fields below fixed for IW=16).
- AW, 4, data-RAM operand address width.
- DW, 8, data word width (immediate zero-extended to DW).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- pc_reset  in  1  synchronous PC clear from control unit.
- pc_enable  in  1  PC increment.
- pc_load  in  1  PC load with branch target from IR.
- ir_enable  in  1  IR capture of imem_data.
- rep_reset  in  1  repeat counter clear.
- rep_enable  in  1  repeat counter advance.
- imem_addr  out  PC_W  instruction memory address (= PC).
- imem_data  in  IW  combinational (asynchronous) instruction-memory read data.
- opcode_new  out  4  imem_data[15:12].
- opcode_old  out  4  ir[15:12].
- rep_stop  out  1  repeat count reached.
- dst_addr  out  AW  ir[11:8] + rep_cnt, mod 2^AW.
- src_addr  out  AW  ir[7:4] + rep_cnt, mod 2^AW.
- imm  out  DW  ir[7:4] zero-extended.
- rep_idx  out  4  current repeat counter value.
- halted  out  1  opcode_old == HLT (4'b1111).

Behaviour:
- All registers update on rising clk edge.
- Instruction fields: opcode [15:12], dst [11:8], src/imm [7:4], rep [3:0] (extra words beyond the first); branch target = ir[PC_W-1:0].
- Reset (`reset`=1): pc=0, ir=0, rep_cnt=0. Hence imem_addr=0, opcode_old=0, rep_idx=0, halted=0, dst_addr=src_addr=0, imm=0, rep_stop=1 (rep field 0).
- `reset` has absolute priority over every other input in the same cycle.
- PC priority: pc_reset > pc_load > pc_enable > hold.
  - pc_load: pc <= ir[PC_W-1:0], target taken from the IR value before this edge.
  - pc_enable: pc <= pc+1, wraps from 2^PC_W-1 to 0.
- IR: ir <= imem_data when ir_enable=1, else hold. Independent of PC ops.
  - ir_enable with pc_load or pc_enable in the same cycle: IR captures the word at the old PC.
- opcode_new is purely combinational from imem_data; zero latency from a PC change.
- Repeat counter (4-bit):
  - rep_reset > rep_enable > hold.
  - rep_enable: increments only while rep_cnt < ir[3:0]. At equality it holds and never wraps.
- rep_stop = (rep_cnt == ir[3:0]), combinational.
  - rep field 0: rep_stop=1 immediately, giving a single-word operation.
  - rep field N: rep_stop asserts after N rep_enable cycles.
- If ir changes while rep_cnt > new ir[3:0]: rep_stop=0 and the counter holds until rep_reset. The control unit guarantees rep_reset on every non-carry state, so this only arises on misuse.
- Address arithmetic is modulo 2^AW and wraps silently.
- No latency beyond one register stage. Outputs derived from ir/rep_cnt change one edge after the control input.
- Control inputs are produced by a negedge-clocked control unit. They are therefore stable a half cycle before each rising edge; no synchronisers.

Decomposition:
- Shared package/include (cpu_isa): opcode constants (AND … HLT) and field position constants (OPC_HI/LO, DST_HI/LO, SRC_HI/LO, REP_HI/LO).
- The control unit includes the same constants.
- One natural sub-module, `rep_counter`: 4-bit saturating counter with rep_reset/rep_enable/limit inputs and cnt/rep_stop outputs.
- PC and IR stay inline.

Test Plan:
1. Reset with imem_data=16'h6123 → pc=0, opcode_old=0, rep_stop=1, opcode_new=4'h6, halted=0.
2. pc_enable 3 cycles from 0 → imem_addr 1,2,3. With PC_W=8 and pc=8'hFF, pc_enable → pc=0.
3. ir_enable with imem_data=16'h6A53 → opcode_old=6, dst_addr=A, src_addr=5, rep_stop=0. Three rep_enable pulses → rep_idx 1,2,3; dst_addr B,C,D; rep_stop=1 on 3rd. A 4th pulse → rep_idx stays 3.
4. IR=16'h5042 with pc_load, pc_enable and ir_enable all high → pc=8'h42 (load beats increment). IR holds the old-PC word.
5. rep_reset and rep_enable together at rep_idx=2 → rep_idx=0. pc_reset with pc_load → pc=0.
6. Mid-operation `reset` at pc=7, rep_idx=2 (rep field 3) → next edge pc=0, ir=0, rep_idx=0, rep_stop=1. imem_data=16'hF000 latched into IR → halted=1.
